// File: rtl/micro_op_pkg.sv
// Shared types for the memory micro-op unit: op/size encodings and the
// access sequencer state encoding.
package micro_op_pkg;

    typedef enum logic [1:0] {
        OP_NONE  = 2'd0,
        OP_LOAD  = 2'd1,
        OP_STORE = 2'd2
    } mem_op_t;

    typedef enum logic [1:0] {
        SIZE_1 = 2'd0,
        SIZE_2 = 2'd1,
        SIZE_4 = 2'd2,
        SIZE_8 = 2'd3
    } mem_size_t;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_REQ1  = 3'd1,
        S_WAIT1 = 3'd2,
        S_REQ2  = 3'd3,
        S_WAIT2 = 3'd4,
        S_RESP  = 3'd5
    } mem_state_t;

    // log2 of the access size, capped at the log2 of the cache word width
    function automatic logic [1:0] clamp_size(input mem_size_t size, input int max_lg);
        return (int'(size) > max_lg) ? 2'(max_lg) : 2'(size);
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Load data merge: extracts the addressed bytes from one or two cache beats
// and sign/zero-extends them to the full cache word.
module mem_lane_align
    import micro_op_pkg::*;
#(
    parameter int DATA_W = 64,
    parameter int OFF_W  = $clog2(DATA_W / 8)
) (
    input  logic [DATA_W-1:0] beat_lo,
    input  logic [DATA_W-1:0] beat_hi,
    input  logic [OFF_W-1:0]  off,
    input  logic [1:0]        size_lg,
    input  logic              is_signed,
    output logic [DATA_W-1:0] data
);

    logic [DATA_W-1:0] raw;
    logic              sign;
    int                nbits;

    always_comb begin
        raw   = DATA_W'({beat_hi, beat_lo} >> {off, 3'b000});
        nbits = 8 << size_lg;
        sign  = 1'b0;
        for (int i = 0; i < DATA_W; i++) begin
            if (i == nbits - 1) sign = is_signed & raw[i];
        end
        for (int i = 0; i < DATA_W; i++) begin
            data[i] = (i < nbits) ? raw[i] : sign;
        end
    end

endmodule

// File: rtl/mem_unit.sv
// Load/store unit: splits misaligned accesses into two dcache beats and returns
// load data or the ALU result downstream.  States: IDLE accept | REQ1/REQ2 issue
// beat | WAIT1/WAIT2 await dc_done | RESP hold result until out_ready.
module mem_unit
    import micro_op_pkg::*;
#(
    parameter int ADDR_W  = 64,
    parameter int DATA_W  = 64,
    parameter int RES_W   = 128,
    parameter int TIMEOUT = 256
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [1:0]          in_op,
    input  logic [1:0]          in_size,
    input  logic                in_signed,
    input  logic [ADDR_W-1:0]   in_addr,
    input  logic [DATA_W-1:0]   in_wdata,
    input  logic [RES_W-1:0]    in_alu_result,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [RES_W-1:0]    out_result,
    output logic                out_err,
    output logic                dc_req,
    output logic                dc_we,
    output logic [ADDR_W-1:0]   dc_addr,
    output logic [DATA_W-1:0]   dc_wdata,
    output logic [DATA_W/8-1:0] dc_be,
    input  logic [DATA_W-1:0]   dc_rdata,
    input  logic                dc_done
);

    localparam int B     = DATA_W / 8;
    localparam int OFF_W = $clog2(B);
    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(TIMEOUT);
    localparam logic [OFF_W:0]   B_BYTES  = (OFF_W + 1)'(B);

    mem_state_t state, state_nxt;

    logic [OFF_W-1:0]    in_off;
    logic [1:0]          in_lg;
    logic [OFF_W:0]      in_n;
    logic                in_split, in_mem, fire;
    logic [2*B-1:0]      in_be;
    logic [2*DATA_W-1:0] in_wide;
    logic                beat1, beat2, waiting, done, tmo;

    logic                is_load_q, signed_q, split_q;
    logic [1:0]          lg_q;
    logic [OFF_W-1:0]    off_q;
    logic [ADDR_W-1:0]   base_q;
    logic [2*B-1:0]      be_q;
    logic [2*DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0]   beat1_q, align_lo, align_hi, ld_data;
    logic [RES_W-1:0]    alu_q;
    logic [CNT_W-1:0]    cnt;

    // Byte enables and store data are laid out across a double-width window
    // so the upper half directly becomes the second beat.
    always_comb begin
        in_off   = in_addr[OFF_W-1:0];
        in_lg    = clamp_size(mem_size_t'(in_size), OFF_W);
        in_n     = (OFF_W + 1)'(1) << in_lg;
        in_split = ({1'b0, in_off} + in_n) > B_BYTES;
        in_mem   = (in_op == OP_LOAD) || (in_op == OP_STORE);
        in_be    = ~({(2*B){1'b1}} << in_n) << in_off;
        in_wide  = {{DATA_W{1'b0}}, in_wdata} << {in_off, 3'b000};
    end

    assign out_valid = (state == S_RESP);
    assign in_ready  = rst_n && (state == S_IDLE) && !out_valid;
    assign fire      = in_valid && in_ready;
    assign beat1     = (state == S_REQ1) || (state == S_WAIT1);
    assign beat2     = (state == S_REQ2) || (state == S_WAIT2);
    assign waiting   = (state == S_WAIT1) || (state == S_WAIT2);
    assign done      = dc_done && waiting;
    assign tmo       = (TIMEOUT > 0) && waiting && !dc_done && (cnt == '0);

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (fire) state_nxt = in_mem ? S_REQ1 : S_RESP;
            S_REQ1:  state_nxt = S_WAIT1;
            S_WAIT1: if (done) state_nxt = split_q ? S_REQ2 : S_RESP;
                     else if (tmo) state_nxt = S_RESP;
            S_REQ2:  state_nxt = S_WAIT2;
            S_WAIT2: if (done || tmo) state_nxt = S_RESP;
            S_RESP:  if (out_ready) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        dc_req   = (state == S_REQ1) || (state == S_REQ2);
        dc_we    = (beat1 || beat2) && !is_load_q;
        dc_addr  = '0;
        dc_be    = '0;
        dc_wdata = '0;
        if (beat1) begin
            dc_addr  = base_q;
            dc_be    = be_q[B-1:0];
            dc_wdata = wdata_q[DATA_W-1:0];
        end else if (beat2) begin
            dc_addr  = base_q + ADDR_W'(B);
            dc_be    = be_q[2*B-1:B];
            dc_wdata = wdata_q[2*DATA_W-1:DATA_W];
        end
    end

    assign align_lo = (state == S_WAIT2) ? beat1_q : dc_rdata;
    assign align_hi = (state == S_WAIT2) ? dc_rdata : '0;

    mem_lane_align #(
        .DATA_W (DATA_W),
        .OFF_W  (OFF_W)
    ) u_lane_align (
        .beat_lo   (align_lo),
        .beat_hi   (align_hi),
        .off       (off_q),
        .size_lg   (lg_q),
        .is_signed (signed_q),
        .data      (ld_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            cnt        <= '0;
            is_load_q  <= 1'b0;
            signed_q   <= 1'b0;
            split_q    <= 1'b0;
            lg_q       <= '0;
            off_q      <= '0;
            base_q     <= '0;
            be_q       <= '0;
            wdata_q    <= '0;
            beat1_q    <= '0;
            alu_q      <= '0;
            out_result <= '0;
            out_err    <= 1'b0;
        end else begin
            state <= state_nxt;
            if (fire) begin
                is_load_q <= (in_op == OP_LOAD);
                signed_q  <= in_signed;
                split_q   <= in_split;
                lg_q      <= in_lg;
                off_q     <= in_off;
                base_q    <= {in_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
                be_q      <= in_be;
                wdata_q   <= (in_op == OP_STORE) ? in_wide : '0;
                alu_q     <= in_alu_result;
                if (!in_mem) out_result <= in_alu_result;
            end
            case (state)
                S_REQ1, S_REQ2:   cnt <= CNT_LOAD;
                S_WAIT1, S_WAIT2: if (cnt != '0) cnt <= cnt - CNT_W'(1);
                default:          cnt <= '0;
            endcase
            if ((state == S_WAIT1) && done) beat1_q <= dc_rdata;
            if (done && (state_nxt == S_RESP)) out_result <= is_load_q ? RES_W'(ld_data) : alu_q;
            if (tmo) begin
                out_result <= '0;
                out_err    <= 1'b1;
            end
            if ((state == S_RESP) && out_ready) out_err <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mem_unit.sv
// Scoreboard bench for mem_unit with a one-cycle-latency dcache responder.
module tb_mem_unit;
    import micro_op_pkg::*;

    localparam int ADDR_W  = 64;
    localparam int DATA_W  = 64;
    localparam int RES_W   = 128;
    localparam int TIMEOUT = 8;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               in_valid = 1'b0;
    logic               in_ready;
    logic [1:0]         in_op = '0;
    logic [1:0]         in_size = '0;
    logic               in_signed = 1'b0;
    logic [ADDR_W-1:0]  in_addr = '0;
    logic [DATA_W-1:0]  in_wdata = '0;
    logic [RES_W-1:0]   in_alu_result = '0;
    logic               out_valid;
    logic               out_ready = 1'b1;
    logic [RES_W-1:0]   out_result;
    logic               out_err;
    logic               dc_req, dc_we;
    logic [ADDR_W-1:0]  dc_addr;
    logic [DATA_W-1:0]  dc_wdata;
    logic [7:0]         dc_be;
    logic [DATA_W-1:0]  dc_rdata;
    logic               dc_done;

    logic               rsp_done = 1'b0, late_done = 1'b0;
    logic [63:0]        rsp_rdata = '0, late_rdata = '0;
    assign dc_done  = rsp_done | late_done;
    assign dc_rdata = rsp_rdata | late_rdata;

    int tests_run = 0;
    int fails = 0;
    int req_count = 0;
    int ans_count = 0;
    int ans_limit = 1 << 30;

    logic [63:0] log_addr[$];
    logic [7:0]  log_be[$];
    logic [63:0] log_wd[$];
    logic        log_we[$];
    logic [63:0] mem [logic [63:0]];

    typedef struct {
        logic [127:0] res;
        logic         err;
        int           lat;
    } exp_t;
    exp_t exp_q[$];

    mem_unit #(
        .ADDR_W (ADDR_W), .DATA_W (DATA_W), .RES_W (RES_W), .TIMEOUT (TIMEOUT)
    ) dut (
        .clk (clk), .rst_n (rst_n),
        .in_valid (in_valid), .in_ready (in_ready), .in_op (in_op), .in_size (in_size),
        .in_signed (in_signed), .in_addr (in_addr), .in_wdata (in_wdata),
        .in_alu_result (in_alu_result),
        .out_valid (out_valid), .out_ready (out_ready), .out_result (out_result),
        .out_err (out_err),
        .dc_req (dc_req), .dc_we (dc_we), .dc_addr (dc_addr), .dc_wdata (dc_wdata),
        .dc_be (dc_be), .dc_rdata (dc_rdata), .dc_done (dc_done)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] init_word(input logic [63:0] a);
        if (a == 64'h1000) return 64'h7766_5544_8022_1100;
        if (a == 64'hFFFF_FFFF_FFFF_FFF8) return 64'hBBAA_0000_0000_0000;
        if (a == 64'h0) return 64'h0000_0000_0000_DDCC;
        return {~a[31:0], a[31:0]};
    endfunction

    function automatic logic [63:0] be_mask(input logic [7:0] be);
        logic [63:0] m = '0;
        for (int l = 0; l < 8; l++) if (be[l]) m[8*l +: 8] = 8'hFF;
        return m;
    endfunction

    function automatic logic [127:0] ext(input logic [63:0] d, input int n, input logic sgn);
        logic [63:0] v = '0;
        for (int i = 0; i < 8*n; i++) v[i] = d[i];
        if (sgn && d[8*n-1]) for (int i = 8*n; i < 64; i++) v[i] = 1'b1;
        return {64'h0, v};
    endfunction

    // dcache model: sees dc_req mid-cycle, answers with dc_done in the next cycle
    initial begin : responder
        logic [63:0] a, wd, w;
        logic [7:0]  be;
        logic        we;
        forever begin
            @(negedge clk);
            if (dc_req === 1'b1) begin
                a = dc_addr; be = dc_be; wd = dc_wdata; we = dc_we;
                req_count++;
                log_addr.push_back(a); log_be.push_back(be);
                log_wd.push_back(wd); log_we.push_back(we);
                if (ans_count < ans_limit) begin
                    ans_count++;
                    @(posedge clk); #1;
                    w = mem.exists(a) ? mem[a] : init_word(a);
                    if (we) begin
                        for (int l = 0; l < 8; l++) if (be[l]) w[8*l +: 8] = wd[8*l +: 8];
                        mem[a] = w;
                    end
                    rsp_rdata = we ? 64'h0 : w;
                    rsp_done  = 1'b1;
                    @(posedge clk); #1;
                    rsp_done  = 1'b0;
                    rsp_rdata = '0;
                end
            end
        end
    end

    task automatic issue(input logic [1:0] op, input logic [1:0] size, input logic sgn,
                         input logic [63:0] addr, input logic [63:0] wd, input logic [127:0] alu);
        int n = 0;
        @(negedge clk);
        in_valid = 1'b1; in_op = op; in_size = size; in_signed = sgn;
        in_addr = addr; in_wdata = wd; in_alu_result = alu;
        while (in_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk); #1;
        in_valid = 1'b0; in_op = 2'd0;
    endtask

    task automatic wait_out(output int lat);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (out_valid !== 1'b1 && lat < 40);
    endtask

    task automatic test_reset();
        #1;
        tests_run++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0 || dc_req !== 1'b0) begin
            fails++;
            $display("FAIL reset_outputs: in_ready=%b out_valid=%b dc_req=%b, want 0 0 0", in_ready, out_valid, dc_req);
        end
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        #1;
        tests_run++;
        if (in_ready !== 1'b1) begin
            fails++;
            $display("FAIL reset_release: in_ready=%b, want 1", in_ready);
        end
    endtask

    task automatic test_none();
        exp_t e; int lat; int base = req_count;
        e.res = 128'hDEAD_BEEF_0000_0000_0000_0000_1234_5678; e.err = 1'b0; e.lat = 1;
        exp_q.push_back(e);
        issue(2'd0, 2'd0, 1'b0, 64'h40, 64'h0, 128'hDEAD_BEEF_0000_0000_0000_0000_1234_5678);
        wait_out(lat);
        e = exp_q.pop_front();
        tests_run++;
        if (out_valid !== 1'b1 || lat != e.lat) begin
            fails++; $display("FAIL none_latency: got %0d (valid %b), want %0d", lat, out_valid, e.lat);
        end
        tests_run++;
        if (out_result !== e.res) begin
            fails++; $display("FAIL none_result: got %h, want %h", out_result, e.res);
        end
        tests_run++;
        if (req_count != base) begin
            fails++; $display("FAIL none_no_dcache: got %0d requests, want 0", req_count - base);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_load_byte();
        exp_t e; int lat; int base = log_addr.size();
        e.res = 128'h0000_0000_0000_0000_FFFF_FFFF_FFFF_FF80; e.err = 1'b0; e.lat = 3;
        exp_q.push_back(e);
        issue(2'd1, 2'd0, 1'b1, 64'h1003, 64'h0, 128'h0);
        wait_out(lat);
        e = exp_q.pop_front();
        tests_run++;
        if (out_valid !== 1'b1 || lat != e.lat) begin
            fails++; $display("FAIL ldb_latency: got %0d (valid %b), want %0d", lat, out_valid, e.lat);
        end
        tests_run++;
        if (out_result !== e.res || out_err !== e.err) begin
            fails++; $display("FAIL ldb_result: got %h err %b, want %h err %b", out_result, out_err, e.res, e.err);
        end
        tests_run++;
        if (log_addr.size() != base + 1) begin
            fails++; $display("FAIL ldb_beats: got %0d, want 1", log_addr.size() - base);
        end else if (log_addr[base] !== 64'h1000 || log_be[base] !== 8'h08 || log_we[base] !== 1'b0) begin
            fails++; $display("FAIL ldb_beat: got addr %h be %h we %b, want 1000 08 0", log_addr[base], log_be[base], log_we[base]);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_store_split();
        exp_t e; int lat; int base = log_addr.size();
        e.res = 128'h5A5A_0000_0000_0000_0000_0000_0000_00A5; e.err = 1'b0; e.lat = 5;
        exp_q.push_back(e);
        issue(2'd2, 2'd3, 1'b0, 64'h1005, 64'h1122_3344_5566_7788, 128'h5A5A_0000_0000_0000_0000_0000_0000_00A5);
        wait_out(lat);
        e = exp_q.pop_front();
        tests_run++;
        if (out_valid !== 1'b1 || lat != e.lat) begin
            fails++; $display("FAIL st_latency: got %0d (valid %b), want %0d", lat, out_valid, e.lat);
        end
        tests_run++;
        if (out_result !== e.res) begin
            fails++; $display("FAIL st_result: got %h, want %h", out_result, e.res);
        end
        tests_run++;
        if (log_addr.size() != base + 2) begin
            fails++; $display("FAIL st_beats: got %0d, want 2", log_addr.size() - base);
        end else begin
            if (log_addr[base] !== 64'h1000 || log_be[base] !== 8'hE0 || log_we[base] !== 1'b1 ||
                (log_wd[base] & be_mask(log_be[base])) !== 64'h6677_8800_0000_0000) begin
                fails++; $display("FAIL st_beat1: got addr %h be %h data %h, want 1000 e0 6677880000000000",
                                  log_addr[base], log_be[base], log_wd[base] & be_mask(log_be[base]));
            end
            tests_run++;
            if (log_addr[base+1] !== 64'h1008 || log_be[base+1] !== 8'h1F || log_we[base+1] !== 1'b1 ||
                (log_wd[base+1] & be_mask(log_be[base+1])) !== 64'h0000_0011_2233_4455) begin
                fails++; $display("FAIL st_beat2: got addr %h be %h data %h, want 1008 1f 0000001122334455",
                                  log_addr[base+1], log_be[base+1], log_wd[base+1] & be_mask(log_be[base+1]));
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_load_wrap();
        exp_t e; int lat; int base = log_addr.size();
        e.res = 128'hDDCC_BBAA; e.err = 1'b0; e.lat = 5;
        exp_q.push_back(e);
        issue(2'd1, 2'd2, 1'b0, 64'hFFFF_FFFF_FFFF_FFFE, 64'h0, 128'h0);
        wait_out(lat);
        e = exp_q.pop_front();
        tests_run++;
        if (out_valid !== 1'b1 || lat != e.lat) begin
            fails++; $display("FAIL wrap_latency: got %0d (valid %b), want %0d", lat, out_valid, e.lat);
        end
        tests_run++;
        if (out_result !== e.res) begin
            fails++; $display("FAIL wrap_result: got %h, want %h", out_result, e.res);
        end
        tests_run++;
        if (log_addr.size() != base + 2) begin
            fails++; $display("FAIL wrap_beats: got %0d, want 2", log_addr.size() - base);
        end else if (log_addr[base] !== 64'hFFFF_FFFF_FFFF_FFF8 || log_be[base] !== 8'hC0 ||
                     log_addr[base+1] !== 64'h0 || log_be[base+1] !== 8'h03) begin
            fails++; $display("FAIL wrap_beat_addr: got %h/%h %h/%h, want fffffffffffffff8/c0 0/03",
                              log_addr[base], log_be[base], log_addr[base+1], log_be[base+1]);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_timeout();
        exp_t e; int lat; int base = req_count;
        out_ready = 1'b0;
        ans_limit = ans_count;
        e.res = '0; e.err = 1'b1; e.lat = 11;
        exp_q.push_back(e);
        issue(2'd1, 2'd3, 1'b0, 64'h2000, 64'h0, 128'h77);
        wait_out(lat);
        e = exp_q.pop_front();
        tests_run++;
        if (out_valid !== 1'b1 || lat != e.lat) begin
            fails++; $display("FAIL tmo_latency: got %0d (valid %b), want %0d", lat, out_valid, e.lat);
        end
        tests_run++;
        if (out_result !== e.res || out_err !== e.err) begin
            fails++; $display("FAIL tmo_result: got %h err %b, want %h err %b", out_result, out_err, e.res, e.err);
        end
        late_rdata = '1; late_done = 1'b1;
        @(negedge clk);
        late_rdata = '0; late_done = 1'b0;
        tests_run++;
        if (out_valid !== 1'b1 || out_result !== 128'h0 || out_err !== 1'b1) begin
            fails++; $display("FAIL tmo_late_done: got valid %b result %h err %b, want 1 0 1", out_valid, out_result, out_err);
        end
        tests_run++;
        if (req_count != base + 1) begin
            fails++; $display("FAIL tmo_requests: got %0d, want 1", req_count - base);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        tests_run++;
        if (out_valid !== 1'b0 || out_err !== 1'b0) begin
            fails++; $display("FAIL tmo_release: got valid %b err %b, want 0 0", out_valid, out_err);
        end
        ans_limit = 1 << 30;
    endtask

    task automatic test_reset_mid();
        exp_t e; int lat;
        ans_limit = ans_count + 1;
        issue(2'd1, 2'd3, 1'b0, 64'h1005, 64'h0, 128'h0);
        repeat (4) @(negedge clk);
        tests_run++;
        if (dc_addr !== 64'h1008 || dc_be !== 8'h1F) begin
            fails++; $display("FAIL rst_pre_wait2: got addr %h be %h, want 1008 1f", dc_addr, dc_be);
        end
        rst_n = 1'b0;
        #1;
        tests_run++;
        if (dc_req !== 1'b0 || dc_we !== 1'b0 || dc_addr !== '0 || dc_be !== '0 || dc_wdata !== '0 ||
            out_valid !== 1'b0 || out_result !== '0 || out_err !== 1'b0 || in_ready !== 1'b0) begin
            fails++; $display("FAIL rst_mid_outputs: got req %b addr %h be %h valid %b res %h err %b rdy %b, want all 0",
                              dc_req, dc_addr, dc_be, out_valid, out_result, out_err, in_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        tests_run++;
        if (in_ready !== 1'b1) begin
            fails++; $display("FAIL rst_mid_ready: got %b, want 1", in_ready);
        end
        ans_limit = 1 << 30;
        @(negedge clk);
        late_rdata = 64'hFFFF; late_done = 1'b1;
        @(negedge clk);
        late_rdata = '0; late_done = 1'b0;
        tests_run++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            fails++; $display("FAIL rst_stale_done: got valid %b ready %b, want 0 1", out_valid, in_ready);
        end
        e.res = 128'h8022_1100; e.err = 1'b0; e.lat = 3;
        exp_q.push_back(e);
        issue(2'd1, 2'd2, 1'b0, 64'h1000, 64'h0, 128'h0);
        wait_out(lat);
        e = exp_q.pop_front();
        tests_run++;
        if (out_valid !== 1'b1 || lat != e.lat || out_result !== e.res || out_err !== e.err) begin
            fails++; $display("FAIL rst_next_op: got lat %0d res %h err %b, want %0d %h %b", lat, out_result, out_err, e.lat, e.res, e.err);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_backpressure();
        exp_t e; int lat;
        out_ready = 1'b0;
        e.res = 128'hCAFE_F00D_0000_0001_0000_0002_0000_0003; e.err = 1'b0; e.lat = 1;
        exp_q.push_back(e);
        issue(2'd0, 2'd0, 1'b0, 64'h0, 64'h0, 128'hCAFE_F00D_0000_0001_0000_0002_0000_0003);
        wait_out(lat);
        e = exp_q.pop_front();
        for (int c = 0; c < 5; c++) begin
            tests_run++;
            if (out_valid !== 1'b1 || out_result !== e.res || in_ready !== 1'b0) begin
                fails++; $display("FAIL bp_hold[%0d]: got valid %b res %h ready %b, want 1 %h 0", c, out_valid, out_result, in_ready, e.res);
            end
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        tests_run++;
        if (out_valid !== 1'b0) begin
            fails++; $display("FAIL bp_release: got valid %b, want 0", out_valid);
        end
    endtask

    task automatic test_back_to_back();
        exp_t e; int lat;
        logic [63:0] addr, data;
        logic [1:0]  size;
        logic        sgn;
        int          n;
        for (int k = 0; k < 8; k++) begin
            addr = 64'h3000 + 64'($urandom_range(0, 63));
            size = 2'($urandom_range(0, 3));
            sgn  = 1'($urandom_range(0, 1));
            data = {$urandom, $urandom};
            n    = 1 << size;
            e.res = 128'(k + 16); e.err = 1'b0; e.lat = (int'(addr[2:0]) + n > 8) ? 5 : 3;
            exp_q.push_back(e);
            e.res = ext(data, n, sgn);
            exp_q.push_back(e);
            issue(2'd2, size, 1'b0, addr, data, 128'(k + 16));
            wait_out(lat);
            e = exp_q.pop_front();
            tests_run++;
            if (out_valid !== 1'b1 || lat != e.lat || out_result !== e.res) begin
                fails++; $display("FAIL b2b_store[%0d]: got lat %0d res %h, want %0d %h", k, lat, out_result, e.lat, e.res);
            end
            issue(2'd1, size, sgn, addr, 64'h0, 128'h0);
            wait_out(lat);
            e = exp_q.pop_front();
            tests_run++;
            if (out_valid !== 1'b1 || lat != e.lat || out_result !== e.res || out_err !== 1'b0) begin
                fails++; $display("FAIL b2b_load[%0d]: got lat %0d res %h, want %0d %h", k, lat, out_result, e.lat, e.res);
            end
        end
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_none();
        test_load_byte();
        test_store_split();
        test_load_wrap();
        test_timeout();
        test_reset_mid();
        test_backpressure();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
